// File: rtl/tremolo_pkg.sv
// Shared constants, LFO direction encoding and width helpers for the tremolo block.
package tremolo_pkg;

  localparam logic WAVE_TRI = 1'b0;
  localparam logic WAVE_SQR = 1'b1;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } lfo_dir_e;

  // Peak LFO amplitude for a given LFO resolution.
  function automatic int unsigned lfo_max_f(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Unity gain (no attenuation) for a given LFO resolution.
  function automatic int unsigned gain_unity_f(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/tremolo_am_if.sv
// Sample/control bundle between the codec side and the tremolo block.
interface tremolo_am_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int RATE_WIDTH  = 24,
  parameter int DEPTH_WIDTH = 8
);
  logic                          en;
  logic                          audio_ready;
  logic signed [DATA_WIDTH-1:0]  x;
  logic [RATE_WIDTH-1:0]         rate;
  logic [DEPTH_WIDTH-1:0]        depth;
  logic                          wave_sel;
  logic signed [DATA_WIDTH-1:0]  y;
  logic                          y_valid;
  logic                          indicator;

  modport master (
    output en, audio_ready, x, rate, depth, wave_sel,
    input  y, y_valid, indicator
  );

  modport slave (
    input  en, audio_ready, x, rate, depth, wave_sel,
    output y, y_valid, indicator
  );
endinterface

// File: rtl/tremolo_am_lfo_gen.sv
// Tick counter plus triangle/square LFO with direction FSM.
//   state   | meaning
//   ST_UP   | lfo increments each tick; the tick reaching LFO_MAX turns around
//   ST_DOWN | lfo decrements each tick; the tick reaching 0 turns around
module lfo_gen
  import tremolo_pkg::*;
#(
  parameter int LFO_WIDTH  = 8,
  parameter int RATE_WIDTH = 24
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  wave_sel,
  output logic [LFO_WIDTH-1:0]  m,
  output logic                  indicator
);

  localparam logic [LFO_WIDTH-1:0] LFO_MAX = LFO_WIDTH'(lfo_max_f(LFO_WIDTH));

  logic [RATE_WIDTH-1:0] r_cnt;
  logic [LFO_WIDTH-1:0]  r_lfo;
  lfo_dir_e              r_state;
  logic                  r_ind;
  logic                  w_rate_nz;
  logic                  w_tick;

  // The >= compare lets a lowered rate fire on the very next cycle instead of wrapping.
  assign w_rate_nz = (rate != '0);
  assign w_tick    = w_rate_nz && (r_cnt >= (rate - RATE_WIDTH'(1)));

  // Tick counter, triangle counter and direction FSM with registered indicator.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lfo   <= '0;
      r_state <= ST_UP;
      r_ind   <= 1'b0;
    end else if (!en) begin
      r_cnt   <= '0;
      r_lfo   <= '0;
      r_state <= ST_UP;
      r_ind   <= 1'b0;
    end else if (w_rate_nz) begin
      if (w_tick) begin
        r_cnt <= '0;
        case (r_state)
          ST_UP: begin
            r_lfo <= r_lfo + LFO_WIDTH'(1);
            if (r_lfo == (LFO_MAX - LFO_WIDTH'(1))) begin
              r_state <= ST_DOWN;
              r_ind   <= 1'b1;
            end
          end
          ST_DOWN: begin
            r_lfo <= r_lfo - LFO_WIDTH'(1);
            if (r_lfo == LFO_WIDTH'(1)) begin
              r_state <= ST_UP;
              r_ind   <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_UP;
            r_ind   <= 1'b0;
          end
        endcase
      end else begin
        r_cnt <= r_cnt + RATE_WIDTH'(1);
      end
    end
  end

  // Modulator selection; wave_sel only matters when the top captures a sample.
  always_comb begin
    m = r_lfo;
    if (wave_sel == WAVE_SQR) m = r_ind ? LFO_MAX : '0;
  end

  assign indicator = r_ind;

endmodule

// File: rtl/tremolo_am.sv
// Amplitude-modulation tremolo: LFO-derived gain and a 3-stage multiply pipeline.
module tremolo_am
  import tremolo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LFO_WIDTH   = 8,
  parameter int RATE_WIDTH  = 24,
  parameter int DEPTH_WIDTH = 8
) (
  input logic        CLK,
  input logic        rst,
  tremolo_am_if.slave bus
);

  localparam logic [LFO_WIDTH:0] GAIN_UNITY = (LFO_WIDTH+1)'(gain_unity_f(LFO_WIDTH));
  localparam int PW = DATA_WIDTH + LFO_WIDTH + 2;
  localparam int DW = DEPTH_WIDTH + LFO_WIDTH;

  logic [LFO_WIDTH-1:0]         w_m;
  logic                         w_ind;
  logic [DW-1:0]                w_dm;
  logic [LFO_WIDTH-1:0]         w_a;
  logic [LFO_WIDTH:0]           w_gain;

  logic signed [DATA_WIDTH-1:0] r_x;
  logic [LFO_WIDTH:0]           r_gain;
  logic                         r_v1;
  logic signed [PW-1:0]         w_x_ext;
  logic signed [PW-1:0]         w_g_ext;
  logic signed [PW-1:0]         r_prod;
  logic                         r_v2;
  logic signed [PW-1:0]         w_shift;
  logic signed [DATA_WIDTH-1:0] r_y;
  logic                         r_y_valid;

  lfo_gen #(
    .LFO_WIDTH (LFO_WIDTH),
    .RATE_WIDTH(RATE_WIDTH)
  ) u_lfo (
    .CLK      (CLK),
    .rst      (rst),
    .en       (bus.en),
    .rate     (bus.rate),
    .wave_sel (bus.wave_sel),
    .m        (w_m),
    .indicator(w_ind)
  );

  // Attenuation a = (depth*m) >> DEPTH_WIDTH; bypass forces unity gain.
  assign w_dm   = {{LFO_WIDTH{1'b0}}, bus.depth} * {{DEPTH_WIDTH{1'b0}}, w_m};
  assign w_a    = w_dm[DEPTH_WIDTH +: LFO_WIDTH];
  assign w_gain = bus.en ? (GAIN_UNITY - {1'b0, w_a}) : GAIN_UNITY;

  // S1: capture sample and gain on audio_ready.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_gain <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= bus.audio_ready;
      if (bus.audio_ready) begin
        r_x    <= bus.x;
        r_gain <= w_gain;
      end
    end
  end

  // Gain is zero-extended so the signed multiply treats it as positive.
  assign w_x_ext = PW'(r_x);
  assign w_g_ext = PW'($signed({1'b0, r_gain}));

  // S2: register the full-width signed product.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_prod <= w_x_ext * w_g_ext;
      r_v2   <= r_v1;
    end
  end

  // gain never exceeds unity, so the floor shift always fits DATA_WIDTH.
  assign w_shift = r_prod >>> LFO_WIDTH;

  // S3: output register and valid strobe.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= r_v2;
      if (r_v2) r_y <= w_shift[DATA_WIDTH-1:0];
    end
  end

  assign bus.y         = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.indicator = w_ind;

endmodule

// File: tb/tb_tremolo_am.sv
// Directed bench for tremolo_am with hand-computed expectations.
module tb_tremolo_am;

  logic CLK = 1'b0;
  logic rst = 1'b1;

  tremolo_am_if #(.DATA_WIDTH(32), .RATE_WIDTH(24), .DEPTH_WIDTH(8)) bus ();

  tremolo_am #(
    .DATA_WIDTH (32),
    .LFO_WIDTH  (8),
    .RATE_WIDTH (24),
    .DEPTH_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Send one sample and check latency, value and one-cycle strobe.
  task automatic send(input string tag, input logic signed [31:0] v, input longint exp);
    bus.audio_ready = 1'b1;
    bus.x           = v;
    tick();
    bus.audio_ready = 1'b0;
    tick();
    chk({tag, "_early"}, longint'(bus.y_valid), 0);
    tick();
    chk({tag, "_vld"}, longint'(bus.y_valid), 1);
    chk(tag, longint'($signed(bus.y)), exp);
    tick();
    chk({tag, "_pulse"}, longint'(bus.y_valid), 0);
  endtask

  // Count cycles until indicator reaches lvl, bounded.
  task automatic wait_ind(input logic lvl, inout int n);
    for (int k = 0; k < 2000; k++) begin
      tick();
      n++;
      if (bus.indicator == lvl) return;
    end
  endtask

  // Restart the LFO from 0/UP with a given rate.
  task automatic restart(input logic [23:0] r);
    bus.en = 1'b0;
    tick();
    bus.rate = r;
    bus.en   = 1'b1;
  endtask

  int n;
  int nv;
  longint got_q[$];

  initial begin
    bus.en          = 1'b0;
    bus.audio_ready = 1'b0;
    bus.x           = '0;
    bus.rate        = '0;
    bus.depth       = '0;
    bus.wave_sel    = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_y", longint'($signed(bus.y)), 0);
    chk("rst_vld", longint'(bus.y_valid), 0);
    chk("rst_ind", longint'(bus.indicator), 0);
    rst = 1'b0;
    tick();

    // Bypass via depth = 0
    bus.en = 1'b1;
    send("byp_max", 32'sh7FFF_FFFF, 64'sd2147483647);
    send("byp_min", 32'sh8000_0000, -64'sd2147483648);

    // Triangle timing with rate = 1
    restart(24'd1);
    n = 0;
    wait_ind(1'b1, n);
    chk("tri_rise", n, 255);
    wait_ind(1'b0, n);
    chk("tri_fall", n, 510);
    wait_ind(1'b1, n);
    chk("tri_period", n, 765);

    // rate = 3: one step every third cycle
    restart(24'd3);
    n = 0;
    wait_ind(1'b1, n);
    chk("rate3_rise", n, 765);

    // Freeze at lfo = 255 (DOWN)
    restart(24'd1);
    n = 0;
    wait_ind(1'b1, n);
    bus.rate = '0;
    repeat (20) tick();
    chk("freeze_ind", longint'(bus.indicator), 1);

    bus.depth    = 8'd255;
    bus.wave_sel = 1'b0;
    send("deep_pos", 32'sd1000, 7);
    send("deep_neg", -32'sd1000, -8);

    bus.depth    = 8'd128;
    bus.wave_sel = 1'b1;
    send("sqr_high", 32'sd256, 129);

    // Reset between E0 and E2
    bus.audio_ready = 1'b1;
    bus.x           = 32'sd500;
    tick();
    bus.audio_ready = 1'b0;
    @(posedge CLK);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_y", longint'($signed(bus.y)), 0);
    chk("mid_rst_vld", longint'(bus.y_valid), 0);
    chk("mid_rst_ind", longint'(bus.indicator), 0);
    tick();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.y_valid) nv++;
    end
    chk("post_rst_vld", nv, 0);

    // Square low phase: LFO is back at 0/UP, rate still 0
    send("sqr_low", 32'sd256, 256);

    // Streaming, depth = 0
    bus.wave_sel = 1'b0;
    bus.depth    = 8'd0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        bus.en    = 1'b0;
        bus.depth = 8'd255;
        bus.rate  = 24'd1;
      end
      got_q.delete();
      nv = 0;
      for (int i = 0; i < 10; i++) begin
        bus.audio_ready = (i < 4);
        bus.x           = i + 1;
        tick();
        if (bus.y_valid) got_q.push_back(longint'($signed(bus.y)));
        if (pass == 1 && bus.indicator) nv++;
      end
      bus.audio_ready = 1'b0;
      chk($sformatf("strm%0d_cnt", pass), got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("strm%0d_y%0d", pass, i),
            (i < got_q.size()) ? got_q[i] : -1, i + 1);
      end
      if (pass == 1) chk("strm_bypass_ind", nv, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tremolo_am.md
# tremolo_am

Parametrised amplitude-modulation tremolo for the guitar-effects audio path. Multiplies each incoming signed sample by a gain derived from an internal low-frequency oscillator (LFO). Rate, depth and waveform (triangle or square) are runtime inputs. Sits between the codec sample interface and the output mixer, and is fully pipelined at one sample per clock.

## Interface
- DATA_WIDTH, 32: sample width, signed two's complement.
- LFO_WIDTH, 8: LFO amplitude resolution; LFO_MAX = 2^LFO_WIDTH-1.
- RATE_WIDTH, 24: width of the rate input, in CLK cycles per LFO step.
- DEPTH_WIDTH, 8: modulation depth resolution.

Ports:
- CLK  in  1  system clock, sole clock domain.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  1 = tremolo active; 0 = bypass, LFO held.
- audio_ready  in  1  one-cycle strobe; x is valid in this cycle.
- x  in  DATA_WIDTH  input sample, signed.
- rate  in  RATE_WIDTH  CLK cycles per LFO step; 0 = LFO frozen.
- depth  in  DEPTH_WIDTH  0 = no modulation; max = deepest.
- wave_sel  in  1  0 = triangle, 1 = square.
- y  out  DATA_WIDTH  output sample, signed, registered.
- y_valid  out  1  one-cycle strobe; y is new in this cycle.
- indicator  out  1  LFO phase LED; high while the LFO descends.

## Operation
- Tick counter:
  - Counts CLK cycles.
  - When count >= rate-1 and rate != 0, it clears and issues one LFO step.
  - rate == 0: counter and LFO hold their current value.
- Triangle LFO:
  - Up/down counter lfo with direction state, states UP and DOWN.
  - UP: lfo increments. The step that reaches LFO_MAX moves the state to DOWN.
  - DOWN: lfo decrements. The step that reaches 0 moves the state to UP.
  - Endpoints are not repeated: 0,1,…,MAX,MAX-1,…,1,0,1,…
  - Period is 2·LFO_MAX steps.
- indicator equals (state == DOWN). It is set on the same edge lfo becomes LFO_MAX and cleared on the same edge lfo becomes 0.
- Modulator value:
  - m = lfo when wave_sel = 0.
  - m = (indicator ? LFO_MAX : 0) when wave_sel = 1.
  - wave_sel changes take effect at the next sample capture. The LFO counter is unaffected.
- Gain arithmetic:
  - a = (depth · m) >> DEPTH_WIDTH, which fits in LFO_WIDTH bits.
  - gain = 2^LFO_WIDTH − a, unsigned, LFO_WIDTH+1 bits. Range is 2..2^LFO_WIDTH for 8/8.
  - Product = x · {0, gain}, signed, DATA_WIDTH+LFO_WIDTH+2 bits.
  - y = product >>> LFO_WIDTH, arithmetic shift (floor). No saturation is needed because gain ≤ 2^LFO_WIDTH.
- depth = 0 gives gain = 2^LFO_WIDTH, so y = x bit-exact.
- en = 0:
  - Gain is forced to 2^LFO_WIDTH.
  - Tick counter and lfo are held at 0, state is UP, indicator is 0.
  - Samples still flow with normal latency.
  - On en rising, the LFO restarts from 0/UP.
- rate change mid-count: the >= compare guarantees a step within one cycle when rate drops below the current count. No lock-up.

## Timing
- Pipeline stages:
  - S1 captures x and gain on the edge where audio_ready = 1 (edge E0).
  - S2 registers the product at E1.
  - S3 registers y and pulses y_valid at E2.
- Latency: y_valid is high for exactly the one cycle following E2.
- Throughput: audio_ready may be high every cycle, giving consecutive y_valid pulses in order. There is no backpressure.
- Gain is sampled from the LFO state present at E0. An LFO step on E0 itself is not seen by that sample.
- Reset values:
  - y = 0, y_valid = 0, indicator = 0.
  - lfo = 0, state UP, tick counter = 0.
  - All pipeline valid bits = 0.
- rst asserted mid-operation: in-flight samples are discarded, and no y_valid is produced for them after release.

## Structure
- Shared package tremolo_pkg contains:
  - LFO_MAX and GAIN_UNITY (2^LFO_WIDTH) derivations.
  - WAVE_TRI / WAVE_SQR constants.
  - LFO direction state encoding (UP/DOWN).
- Sub-module lfo_gen holds the tick counter, triangle counter, direction FSM, indicator and square derivation. Its outputs are m and indicator.
- tremolo_am holds the gain computation and the 3-stage multiply pipeline.

## Test plan
1. Reset: inject samples, assert rst between E0 and E2 → y = 0, y_valid = 0 and indicator = 0 immediately; no y_valid after release.
2. Bypass: depth = 0, en = 1, x = 32'h7FFF_FFFF, then x = 32'h8000_0000, each with audio_ready → y equals x exactly, y_valid on the cycle after E2.
3. Triangle with rate = 1, LFO_WIDTH = 8:
   - lfo steps every cycle: 0→255 in 255 steps, then back to 0.
   - indicator rises on the edge lfo = 255 and falls on the edge lfo = 0.
   - Period is 510 cycles.
   - rate = 0 freezes lfo.
4. Depth arithmetic: freeze lfo at 255, depth = 255 → gain = 2. x = 1000 → y = 7; x = −1000 → y = −8.
5. Square: wave_sel = 1, depth = 128, x = 256 → y = 129 while indicator = 1, y = 256 while indicator = 0.
6. Streaming: depth = 0, audio_ready high for 4 consecutive cycles with x = 1,2,3,4 → 4 consecutive y_valid pulses with y = 1,2,3,4. Repeat with en = 0 and depth = 255: same output, indicator stays 0.
